// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared definitions for the CPU bus arbiter and its OAM DMA engine.
// Holds the default DMA trigger/destination addresses and the DMA state
// encoding, which is also meant for any PPU-side OAM monitor.
package cpu_bus_arbiter_pkg;

    localparam logic [15:0] OAM_DMA_ADDR_DEF = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR_DEF = 16'h2004;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_DUMMY,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

endpackage

// File: rtl/cpu_bus_arbiter_oam_dma_engine.sv
// OAM DMA engine: watches the client-selected bus for a write to the DMA
// trigger address, then copies 256 bytes from page {page,00} to OAMDATA.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   req_addr/data/we   client-selected bus request (seen while idle)
//   dma_active         DMA owns the bus (state != IDLE)
//   dma_addr           address DMA drives onto the bus
//   dma_write_en       DMA write strobe
//   dma_data_sel       1: bus write data comes from bus_data_in
module oam_dma_engine
    import cpu_bus_arbiter_pkg::*;
#(
    parameter logic [15:0] OAM_DMA_ADDR = OAM_DMA_ADDR_DEF,
    parameter logic [15:0] OAMDATA_ADDR = OAMDATA_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_data,
    input  logic        req_write_en,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_write_en,
    output logic        dma_data_sel
);

    dma_state_t state;
    dma_state_t state_next;
    logic [7:0] page;
    logic [7:0] idx;
    logic       parity;
    logic       start;

    // Free-running cycle parity; decides whether an alignment cycle is needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DMA_IDLE;
            page  <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                page <= req_data;
                idx  <= '0;
            end else if (state == DMA_WRITE) begin
                idx <= idx + 8'd1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        start        = 1'b0;
        dma_addr     = OAM_DMA_ADDR;
        dma_write_en = 1'b0;
        dma_data_sel = 1'b0;
        case (state)
            DMA_IDLE: begin
                if (req_write_en && (req_addr == OAM_DMA_ADDR)) begin
                    start      = 1'b1;
                    state_next = DMA_DUMMY;
                end
            end
            DMA_DUMMY: begin
                state_next = parity ? DMA_ALIGN : DMA_READ;
            end
            DMA_ALIGN: begin
                state_next = DMA_READ;
            end
            DMA_READ: begin
                // No carry into page: page $FF wraps within $FF00-$FFFF.
                dma_addr   = {page, idx};
                state_next = DMA_WRITE;
            end
            DMA_WRITE: begin
                dma_addr     = OAMDATA_ADDR;
                dma_write_en = 1'b1;
                dma_data_sel = 1'b1;
                state_next   = (idx == 8'hFF) ? DMA_IDLE : DMA_READ;
            end
            default: begin
                state_next = DMA_IDLE;
            end
        endcase
    end

    assign dma_active = (state != DMA_IDLE);

endmodule

// File: rtl/cpu_bus_arbiter.sv
// CPU memory bus arbiter. Multiplexes the interrupt handler and instruction
// executor onto the single bus (interrupt handler wins while accessing
// memory) and hands the bus to OAM DMA after a write to the trigger address.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   ie_addr/ie_data_out/ie_write_en IE bus request
//   ih_addr/ih_data_out/ih_write_en interrupt handler bus request
//   ih_accessing_memory             interrupt handler owns the bus
//   bus_data_in                     read data, valid one cycle after address
//   bus_addr/bus_data_out/bus_write_en  bus outputs
//   cpu_data_in                     read data returned to both clients
//   halt, dma_busy                  DMA in progress, stalls both clients
module cpu_bus_arbiter
    import cpu_bus_arbiter_pkg::*;
#(
    parameter logic [15:0] OAM_DMA_ADDR = OAM_DMA_ADDR_DEF,
    parameter logic [15:0] OAMDATA_ADDR = OAMDATA_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ie_addr,
    input  logic [7:0]  ie_data_out,
    input  logic        ie_write_en,
    input  logic [15:0] ih_addr,
    input  logic [7:0]  ih_data_out,
    input  logic        ih_write_en,
    input  logic        ih_accessing_memory,
    input  logic [7:0]  bus_data_in,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    output logic        bus_write_en,
    output logic [7:0]  cpu_data_in,
    output logic        halt,
    output logic        dma_busy
);

    logic [15:0] cli_addr;
    logic [7:0]  cli_data;
    logic        cli_write_en;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_write_en;
    logic        dma_data_sel;

    // Client selection is kept separate from the DMA override so the engine
    // can watch for the trigger write without a combinational loop.
    always_comb begin
        if (ih_accessing_memory) begin
            cli_addr     = ih_addr;
            cli_data     = ih_data_out;
            cli_write_en = ih_write_en;
        end else begin
            cli_addr     = ie_addr;
            cli_data     = ie_data_out;
            cli_write_en = ie_write_en;
        end
    end

    oam_dma_engine #(
        .OAM_DMA_ADDR (OAM_DMA_ADDR),
        .OAMDATA_ADDR (OAMDATA_ADDR)
    ) u_dma (
        .clk          (clk),
        .rst          (rst),
        .req_addr     (cli_addr),
        .req_data     (cli_data),
        .req_write_en (cli_write_en),
        .dma_active   (dma_active),
        .dma_addr     (dma_addr),
        .dma_write_en (dma_write_en),
        .dma_data_sel (dma_data_sel)
    );

    always_comb begin
        if (dma_active) begin
            bus_addr     = dma_addr;
            bus_write_en = dma_write_en;
            bus_data_out = dma_data_sel ? bus_data_in : '0;
        end else begin
            bus_addr     = cli_addr;
            bus_write_en = cli_write_en;
            bus_data_out = cli_data;
        end
    end

    assign cpu_data_in = bus_data_in;
    assign halt        = dma_active;
    assign dma_busy    = dma_active;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
module tb_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ie_addr = '0;
    logic [7:0]  ie_data_out = '0;
    logic        ie_write_en = 1'b0;
    logic [15:0] ih_addr = '0;
    logic [7:0]  ih_data_out = '0;
    logic        ih_write_en = 1'b0;
    logic        ih_accessing_memory = 1'b0;
    logic [7:0]  bus_data_in = '0;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_write_en;
    logic [7:0]  cpu_data_in;
    logic        halt;
    logic        dma_busy;

    int n_checks = 0;
    int n_pass = 0;

    cpu_bus_arbiter #(
        .OAM_DMA_ADDR (16'h4014),
        .OAMDATA_ADDR (16'h2004)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ie_addr             (ie_addr),
        .ie_data_out         (ie_data_out),
        .ie_write_en         (ie_write_en),
        .ih_addr             (ih_addr),
        .ih_data_out         (ih_data_out),
        .ih_write_en         (ih_write_en),
        .ih_accessing_memory (ih_accessing_memory),
        .bus_data_in         (bus_data_in),
        .bus_addr            (bus_addr),
        .bus_data_out        (bus_data_out),
        .bus_write_en        (bus_write_en),
        .cpu_data_in         (cpu_data_in),
        .halt                (halt),
        .dma_busy            (dma_busy)
    );

    always #5 clk = ~clk;

    // Memory image: page $02 holds $0200+i = i.
    function automatic logic [7:0] memfn(input logic [15:0] a);
        return a[7:0] + a[15:8] - 8'd2;
    endfunction

    // Memory returns data one cycle after the address.
    always @(posedge clk) bus_data_in <= memfn(bus_addr);

    // Cycles since reset release; its LSB is the DUT's cycle parity.
    int cnt = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 0;
        else      cnt <= cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // A DMA is a schedule of lead cycles (1 or 2) followed by 256 (read, write)
    // pairs; m_k indexes the cycle within that schedule.
    logic       m_act = 1'b0;
    int         m_k = 0;
    int         m_lead = 1;
    logic [7:0] m_page = '0;

    always @(negedge clk) begin
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic        e_we;
        logic        chk_data;
        int          j;
        logic [7:0]  ib;
        e_addr   = ih_accessing_memory ? ih_addr : ie_addr;
        e_data   = ih_accessing_memory ? ih_data_out : ie_data_out;
        e_we     = ih_accessing_memory ? ih_write_en : ie_write_en;
        chk_data = 1'b1;
        if (!rst) begin
            m_act = 1'b0;
            check("rst_halt", halt, 1'b0);
            check("rst_busy", dma_busy, 1'b0);
        end else if (m_act) begin
            if (m_k < m_lead) begin
                e_addr = 16'h4014; e_we = 1'b0; chk_data = 1'b0;
            end else begin
                j  = m_k - m_lead;
                ib = 8'(j / 2);
                if (j % 2 == 0) begin
                    e_addr = {m_page, ib}; e_we = 1'b0; chk_data = 1'b0;
                end else begin
                    e_addr = 16'h2004; e_we = 1'b1; e_data = memfn({m_page, ib});
                end
            end
            check("dma_halt", halt, 1'b1);
            check("dma_busy", dma_busy, 1'b1);
            m_k++;
            if (m_k == m_lead + 512) m_act = 1'b0;
        end else begin
            check("idle_halt", halt, 1'b0);
            check("idle_busy", dma_busy, 1'b0);
            if (e_we && e_addr == 16'h4014) begin
                m_act  = 1'b1;
                m_k    = 0;
                m_page = e_data;
                // Align cycle needed when parity in the following cycle is 1.
                m_lead = (cnt[0] == 1'b1) ? 1 : 2;
            end
        end
        check("bus_addr", bus_addr, e_addr);
        check("bus_we", bus_write_en, e_we);
        if (chk_data) check("bus_data", bus_data_out, e_data);
        check("cpu_data_in", cpu_data_in, bus_data_in);
    end

    // ---------------- directed stimulus ----------------
    logic [7:0]  wr_data [256];
    int          len, nwr, nrd;
    logic [15:0] rd_min, rd_max, rd_first;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ie_addr = 16'h1234; ie_data_out = 8'h00; ie_write_en = 1'b0;
        ih_addr = 16'h0000; ih_data_out = 8'h00; ih_write_en = 1'b0;
        ih_accessing_memory = 1'b0;
    endtask

    // Trigger a DMA so that the cycle after the trigger has the given parity,
    // then collect everything that happens while halt is high.
    task automatic run_dma(input logic [7:0] page, input logic dummy_par);
        cyc();
        if (cnt[0] == dummy_par) cyc();
        ie_addr = 16'h4014; ie_data_out = page; ie_write_en = 1'b1;
        cyc();
        idle_inputs();
        len = 0; nwr = 0; nrd = 0;
        rd_min = 16'hFFFF; rd_max = 16'h0000; rd_first = 16'h0000;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (halt) begin
                len++;
                if (bus_write_en && bus_addr == 16'h2004) begin
                    if (nwr < 256) wr_data[nwr] = bus_data_out;
                    nwr++;
                end else if (!bus_write_en && bus_addr != 16'h4014) begin
                    if (nrd == 0) rd_first = bus_addr;
                    if (bus_addr < rd_min) rd_min = bus_addr;
                    if (bus_addr > rd_max) rd_max = bus_addr;
                    nrd++;
                end
            end else if (len > 0) begin
                break;
            end
        end
    endtask

    initial begin
        int bad;
        logic found;
        idle_inputs();
        ie_addr = 16'hABCD;
        repeat (3) cyc();
        @(negedge clk);
        check("reset_halt", halt, 1'b0);
        check("reset_bus_follows_ie", bus_addr, 16'hABCD);
        cyc();
        rst = 1'b1;
        idle_inputs();

        // IE write
        cyc();
        ie_addr = 16'h0300; ie_data_out = 8'h12; ie_write_en = 1'b1;
        @(negedge clk);
        check("ie_addr", bus_addr, 16'h0300);
        check("ie_data", bus_data_out, 8'h12);
        check("ie_we", bus_write_en, 1'b1);
        check("ie_halt", halt, 1'b0);

        // Interrupt handler owns the bus
        cyc();
        ih_accessing_memory = 1'b1; ih_addr = 16'h01FD; ih_write_en = 1'b0;
        ie_addr = 16'h4000; ie_data_out = 8'h55; ie_write_en = 1'b1;
        @(negedge clk);
        check("ih_addr", bus_addr, 16'h01FD);
        check("ih_we", bus_write_en, 1'b0);
        cyc();
        ie_addr = 16'h4014; ie_data_out = 8'h02;
        ih_addr = 16'h0400; ih_data_out = 8'h77; ih_write_en = 1'b1;
        @(negedge clk);
        check("ih_wins_data", bus_data_out, 8'h77);
        check("ih_wins_addr", bus_addr, 16'h0400);
        cyc();
        idle_inputs();
        @(negedge clk);
        check("ie_masked_no_dma", halt, 1'b0);

        // DMA with parity 0 at DUMMY
        run_dma(8'h02, 1'b0);
        check("dma513_len", len, 513);
        check("dma513_nwr", nwr, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (wr_data[i] !== 8'(i)) bad++;
        check("dma513_data_bad", bad, 0);
        check("dma513_last", wr_data[255], 8'hFF);
        check("dma513_first_rd", rd_first, 16'h0200);

        // DMA with parity 1 at DUMMY
        run_dma(8'h02, 1'b1);
        check("dma514_len", len, 514);
        check("dma514_nwr", nwr, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (wr_data[i] !== 8'(i)) bad++;
        check("dma514_data_bad", bad, 0);

        // Page $FF stays inside $FF00-$FFFF
        run_dma(8'hFF, 1'b0);
        check("pgff_nrd", nrd, 256);
        check("pgff_min", rd_min, 16'hFF00);
        check("pgff_max", rd_max, 16'hFFFF);
        check("pgff_first_data", wr_data[0], 8'hFD);

        // Reset at idx=$80
        cyc();
        ie_addr = 16'h4014; ie_data_out = 8'h02; ie_write_en = 1'b1;
        cyc();
        idle_inputs();
        found = 1'b0;
        for (int c = 0; c < 700 && !found; c++) begin
            @(negedge clk);
            if (halt && !bus_write_en && bus_addr == 16'h0280) found = 1'b1;
        end
        check("mid_dma_reached", found, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("midrst_halt", halt, 1'b0);
        check("midrst_busy", dma_busy, 1'b0);
        check("midrst_bus_ie", bus_addr, 16'h1234);
        cyc();
        cyc();
        rst = 1'b1;
        run_dma(8'h03, 1'b0);
        check("restart_first_rd", rd_first, 16'h0300);
        check("restart_nwr", nwr, 256);
        check("restart_len", len, 513);

        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Owns the CPU memory bus directly downstream of the interrupt handler and the instruction executor (IE). It multiplexes the two clients' address, data and write-enable lines onto the single bus, with the interrupt handler winning while it is accessing memory. It also runs OAM DMA: a write to $4014 halts both clients and copies 256 bytes from page $XX00 to OAMDATA ($2004).

## Interface
Parameters:
- OAM_DMA_ADDR, 16'h4014, write address that triggers DMA
- OAMDATA_ADDR, 16'h2004, DMA destination address

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- ie_addr  in  16  IE bus address
- ie_data_out  in  8  IE write data
- ie_write_en  in  1  IE write strobe
- ih_addr  in  16  interrupt handler bus address
- ih_data_out  in  8  interrupt handler write data
- ih_write_en  in  1  interrupt handler write strobe
- ih_accessing_memory  in  1  interrupt handler owns the bus
- bus_data_in  in  8  read data from memory map, valid one cycle after the address
- bus_addr  out  16  bus address
- bus_data_out  out  8  bus write data
- bus_write_en  out  1  bus write strobe
- cpu_data_in  out  8  read data returned to both clients, equal to bus_data_in
- halt  out  1  stalls the IE and the interrupt handler
- dma_busy  out  1  DMA in progress, equal to halt

## Operation
- Bus mux (combinational), in priority order:
  - DMA state not IDLE: DMA drives the bus.
  - Otherwise, ih_accessing_memory=1: interrupt handler drives the bus.
  - Otherwise: IE drives the bus.
- States: IDLE, DUMMY, ALIGN, READ, WRITE.
- IDLE: if bus_write_en=1 and bus_addr==OAM_DMA_ADDR, latch page<=bus_data_out, clear idx, go to DUMMY. The triggering write still reaches the bus unchanged.
- DUMMY: bus_write_en=0, bus_addr held at OAM_DMA_ADDR. Go to ALIGN if parity=1, else to READ.
- ALIGN: same outputs as DUMMY. Go to READ.
- READ: bus_addr={page,idx}, bus_write_en=0. Go to WRITE.
- WRITE: bus_addr=OAMDATA_ADDR, bus_data_out=bus_data_in (combinational pass-through), bus_write_en=1. Then idx<=idx+1.
  - If idx==8'hFF, go to IDLE.
  - Otherwise go to READ.
- parity: 1-bit register toggled every clk, reset 0. Never paused.
- idx: 8 bits. The address is {page,idx} with no carry into page, so page $FF reads $FF00–$FFFF.
- halt = dma_busy = (state != IDLE), registered.
- A write to $4014 while DMA is active cannot occur, because the bus is owned by DMA. Any such write is ignored.

## Timing
- Reset values: state=IDLE, page=0, idx=0, parity=0, halt=0, dma_busy=0. Bus outputs follow the IE inputs while in IDLE.
- halt asserts on the edge after the trigger write cycle.
- Halted length is 513 cycles (parity 0 at DUMMY) or 514 cycles (parity 1): 1 dummy, optional align, then 256×(READ,WRITE).
- halt deasserts on the edge after the final WRITE (idx=$FF). The IE resumes on the following cycle.
- Reset mid-DMA: immediate return to IDLE with halt=0. No partial-state resume.
- The interrupt handler and the IE never both present valid writes in the same cycle. The interrupt handler wins if they do.

## Structure
- Shared include nes_cpu_defs.vh holds:
  - OAM_DMA_ADDR and OAMDATA_ADDR localparams
  - DMA state encodings, shared with any PPU-side OAM monitor
- One sub-module is natural: oam_dma_engine, containing the state machine, idx, page and parity. It outputs dma_active, dma_addr, dma_write_en and dma_data_sel.
- The top level keeps only the priority mux and the pass-through of cpu_data_in.

## Test plan
- IE writes $12 to $0300 with ih_accessing_memory=0 → bus_addr=$0300, bus_data_out=$12, bus_write_en=1, halt=0.
- ih_accessing_memory=1 with ih_addr=$01FD and IE presenting $4000 → bus_addr=$01FD. IE lines ignored, no DMA.
- IE writes $02 to $4014 with parity=0 at DUMMY, memory $0200+i=i → 256 writes to $2004 carrying $00..$FF in order, halt high for exactly 513 cycles.
- Same trigger with parity=1 at DUMMY → halt high for 514 cycles, data identical.
- Page $FF DMA → reads $FF00..$FFFF only, never $0000.
- rst low at idx=$80 → halt=0 and state=IDLE immediately. The next $4014 write restarts from idx=0.
